uart_frame_controller: RTL

//  Sequences the byte stream from the UART receiver into command frames.

---
 rtl/uart_frame_pkg.sv | 19 +
 rtl/uart_frame_controller_counter.sv | 29 ++
 rtl/uart_frame_controller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART command-frame sequencer.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        HUNT,
        ID,
        LEN,
        PAYLOAD,
        CHECK,
        HOLD
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/uart_frame_controller_counter.sv
// Inter-byte idle timer; only built when UART_FRAME_TIMEOUT_EN is defined.
`ifdef UART_FRAME_TIMEOUT_EN
module counter #(
    parameter int unsigned W = 20
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         clear_in,
    input  logic [W-1:0] period_in,
    output logic         done_out
);

    logic [W-1:0] count_q;

    // Parks at period-1 so done_out stays asserted until the owner clears it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else if (clear_in) begin
            count_q <= '0;
        end else if (count_q != period_in - W'(1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign done_out = !clear_in && (count_q == period_in - W'(1));

endmodule
`endif

// File: rtl/uart_frame_controller.sv
// Frames the UART byte stream (SYNC, ID, LEN, payload, CHK) into commands.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_controller
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned MAX_PAYLOAD    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    localparam int unsigned LEN_W         = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     byte_valid_in,
    input  logic [7:0]               byte_in,
    output logic                     cmd_valid_out,
    input  logic                     cmd_ready_in,
    output logic [7:0]               cmd_id_out,
    output logic [LEN_W-1:0]         cmd_len_out,
    output logic [8*MAX_PAYLOAD-1:0] cmd_payload_out,
    output logic                     err_chk_out,
    output logic                     err_len_out,
    output logic                     err_timeout_out,
    output logic                     drop_out,
    output logic [7:0]               err_count_out
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    state_t           state_q;
    logic [7:0]       sum_q;
    logic [LEN_W-1:0] idx_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       id_q;
    logic             valid_q;
    logic             err_chk_q;
    logic             err_len_q;
    logic             drop_q;
    logic [7:0]       err_count_q;

    logic             tmo_hit;
    logic             byte_is_sync;
    logic [7:0]       sum_d;
    logic             len_bad_d;
    logic             chk_bad_d;
    logic             tmo_d;
    logic             err_any_d;

    always_comb begin
        byte_is_sync = (byte_in == SYNC_BYTE);
        sum_d        = chk_add(sum_q, byte_in);
        len_bad_d    = (state_q == LEN) && byte_valid_in && (byte_in > MAX_LEN);
        chk_bad_d    = (state_q == CHECK) && byte_valid_in && (byte_in != sum_q);
        // A byte on the expiry cycle wins over the timeout.
        tmo_d        = tmo_hit && !byte_valid_in &&
                       (state_q inside {ID, LEN, PAYLOAD, CHECK});
        err_any_d    = len_bad_d || chk_bad_d || tmo_d;
    end

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic tmr_clear;
    logic err_timeout_q;

    assign tmr_clear = byte_valid_in || (state_q == HUNT) || (state_q == HOLD);

    counter #(
        .W(TMR_W)
    ) u_timer (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (tmr_clear),
        .period_in (TMR_W'(TIMEOUT_CYCLES)),
        .done_out  (tmo_hit)
    );

    assign err_timeout_out = err_timeout_q;
`else
    assign tmo_hit         = 1'b0;
    assign err_timeout_out = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= HUNT;
            sum_q         <= '0;
            idx_q         <= '0;
            len_q         <= '0;
            id_q          <= '0;
            valid_q       <= 1'b0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            drop_q        <= 1'b0;
            err_count_q   <= '0;
`ifdef UART_FRAME_TIMEOUT_EN
            err_timeout_q <= 1'b0;
`endif
        end else begin
            err_chk_q <= chk_bad_d;
            err_len_q <= len_bad_d;
            drop_q    <= (state_q == HOLD) && byte_valid_in;
`ifdef UART_FRAME_TIMEOUT_EN
            err_timeout_q <= tmo_d;
`endif
            if (err_any_d && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end

            if (tmo_d) begin
                state_q <= HUNT;
            end else begin
                case (state_q)
                    HUNT: begin
                        if (byte_valid_in && byte_is_sync) begin
                            state_q <= ID;
                        end
                    end
                    ID: begin
                        if (byte_valid_in) begin
                            id_q    <= byte_in;
                            sum_q   <= byte_in;
                            state_q <= LEN;
                        end
                    end
                    LEN: begin
                        if (byte_valid_in) begin
                            if (len_bad_d) begin
                                state_q <= HUNT;
                            end else begin
                                len_q   <= byte_in[LEN_W-1:0];
                                sum_q   <= sum_d;
                                idx_q   <= '0;
                                state_q <= (byte_in == 8'd0) ? CHECK : PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (byte_valid_in) begin
                            sum_q <= sum_d;
                            idx_q <= idx_q + LEN_W'(1);
                            if (idx_q == len_q - LEN_W'(1)) begin
                                state_q <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (byte_valid_in) begin
                            if (chk_bad_d) begin
                                state_q <= HUNT;
                            end else begin
                                state_q <= HOLD;
                                valid_q <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (cmd_ready_in) begin
                            state_q <= HUNT;
                            valid_q <= 1'b0;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    // One register per payload slot; cleared together when a new SYNC is seen.
    for (genvar gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_payload
        logic [7:0] byte_q;

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                byte_q <= '0;
            end else if ((state_q == HUNT) && byte_valid_in && byte_is_sync) begin
                byte_q <= '0;
            end else if ((state_q == PAYLOAD) && byte_valid_in && (idx_q == LEN_W'(gi))) begin
                byte_q <= byte_in;
            end
        end

        assign cmd_payload_out[8*gi +: 8] = byte_q;
    end

    assign cmd_valid_out = valid_q;
    assign cmd_id_out    = id_q;
    assign cmd_len_out   = len_q;
    assign err_chk_out   = err_chk_q;
    assign err_len_out   = err_len_q;
    assign drop_out      = drop_q;
    assign err_count_out = err_count_q;

endmodule
